// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg
// Shared CPU constants used by decode, write-back and the register file.
//   DATA_W   : register data width
//   ADDR_W   : register number width (2^ADDR_W architectural registers)
//   REG_ZERO : hard-wired zero register number
package reg_file_sb_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int unsigned REG_ZERO = 0;
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if
// Decode-stage bundle between the read-select / issue logic (master) and the
// register file with its pending-write scoreboard (slave).
//   r1, r2, r1_used, r2_used       : operand selects and "really read" flags
//   r1_dout, r2_dout               : operand data back to the ID/EX latch
//   issue_valid, issue_wr, issue_dst : instruction leaving ID and its destination
//   we, wb_num, wb_din             : write-back port
//   stall, sb_err                  : hold ID / sticky scoreboard error
interface reg_file_sb_if
    import reg_file_sb_pkg::*;
    ();
    logic [ADDR_W-1:0] r1;
    logic [ADDR_W-1:0] r2;
    logic              r1_used;
    logic              r2_used;
    logic [DATA_W-1:0] r1_dout;
    logic [DATA_W-1:0] r2_dout;
    logic              issue_valid;
    logic              issue_wr;
    logic [ADDR_W-1:0] issue_dst;
    logic              we;
    logic [ADDR_W-1:0] wb_num;
    logic [DATA_W-1:0] wb_din;
    logic              stall;
    logic              sb_err;

    modport master (
        output r1, r2, r1_used, r2_used, issue_valid, issue_wr, issue_dst,
               we, wb_num, wb_din,
        input  r1_dout, r2_dout, stall, sb_err
    );

    modport slave (
        input  r1, r2, r1_used, r2_used, issue_valid, issue_wr, issue_dst,
               we, wb_num, wb_din,
        output r1_dout, r2_dout, stall, sb_err
    );
endinterface

// File: rtl/reg_file_sb_sb_counter.sv
// sb_counter
// Saturating up/down pending-write counter for one register.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc, dec   : count an issued write / retire a write-back
//   cnt        : current pending count
//   max        : count is at its saturation value
module sb_counter
    import reg_file_sb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             max
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Simultaneous inc and dec cancel; both ends clamp.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign max = (cnt_q == '1);
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb
// Decode-stage register file with same-cycle write-back bypass and a
// per-register pending-write scoreboard that raises stall on unresolved
// operands or a saturated destination counter.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (clears storage, counters, sb_err)
//   bus   : reg_file_sb_if.slave (operand reads, issue, write-back, stall, sb_err)
// Parameter CNT_W: pending counter width per register.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_sb_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              sb_err_q;
    logic              sb_err_d;

    logic [CNT_W-1:0]  pend [NREG];
    logic [NREG-1:0]   pend_max;
    logic [NREG-1:0]   inc_sel;
    logic [NREG-1:0]   dec_sel;

    logic              wb_live;
    logic              inc;
    logic              dec;
    logic              stall;
    logic              r1_unres;
    logic              r2_unres;
    logic [CNT_W-1:0]  pend_wb;
    logic [CNT_W-1:0]  pend_r1;
    logic [CNT_W-1:0]  pend_r2;

    assign wb_live = bus.we && (bus.wb_num != ZERO);
    assign pend_wb = pend[bus.wb_num];
    assign pend_r1 = pend[bus.r1];
    assign pend_r2 = pend[bus.r2];

    assign dec = wb_live && (pend_wb != '0);
    assign inc = bus.issue_valid && !stall && bus.issue_wr && (bus.issue_dst != ZERO);

    // A last outstanding write retiring this cycle is resolved: the bypass
    // hands over its data. Register 0 never has a pending count.
    assign r1_unres = (pend_r1 != '0) &&
                      !(dec && (bus.wb_num == bus.r1) && (pend_r1 == CNT_W'(1)));
    assign r2_unres = (pend_r2 != '0) &&
                      !(dec && (bus.wb_num == bus.r2) && (pend_r2 == CNT_W'(1)));

    // Uses pre-increment counts, so an instruction never stalls on itself.
    assign stall = (bus.r1_used && r1_unres) ||
                   (bus.r2_used && r2_unres) ||
                   (bus.issue_wr && pend_max[bus.issue_dst]);

    for (genvar i = 0; i < NREG; i++) begin : g_pend
        assign inc_sel[i] = inc && (bus.issue_dst == ADDR_W'(i));
        assign dec_sel[i] = dec && (bus.wb_num == ADDR_W'(i));

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc_sel[i]),
            .dec   (dec_sel[i]),
            .cnt   (pend[i]),
            .max   (pend_max[i])
        );
    end

    always_comb begin
        bus.r1_dout = regs_q[bus.r1];
        if (bus.we && (bus.r1 != ZERO) && (bus.wb_num == bus.r1)) begin
            bus.r1_dout = bus.wb_din;
        end
        bus.r2_dout = regs_q[bus.r2];
        if (bus.we && (bus.r2 != ZERO) && (bus.wb_num == bus.r2)) begin
            bus.r2_dout = bus.wb_din;
        end
    end

    // A stray write-back still updates storage; it only flags the error.
    always_comb begin
        regs_d = regs_q;
        if (wb_live) begin
            regs_d[bus.wb_num] = bus.wb_din;
        end
        sb_err_d = sb_err_q || (wb_live && (pend_wb == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign bus.stall  = stall;
    assign bus.sb_err = sb_err_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb
// Directed bench for reg_file_sb. The driver applies one input vector per
// cycle and queues the hand-computed response; a monitor on the falling edge
// pops each entry and compares the masked fields.
module tb_reg_file_sb;
    import reg_file_sb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    reg_file_sb_if bus();

    reg_file_sb #(.CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // mask bits: [3] r1_dout, [2] r2_dout, [1] stall, [0] sb_err
    typedef struct {
        string       name;
        logic [3:0]  mask;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        st;
        logic        err;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input string f, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s got=%h want=%h", n, f, got, want);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.mask[3]) chk(e.name, "r1_dout", bus.r1_dout, e.d1);
            if (e.mask[2]) chk(e.name, "r2_dout", bus.r2_dout, e.d2);
            if (e.mask[1]) chk(e.name, "stall", {31'd0, bus.stall}, {31'd0, e.st});
            if (e.mask[0]) chk(e.name, "sb_err", {31'd0, bus.sb_err}, {31'd0, e.err});
        end
    end

    task automatic drv(input logic [4:0] a1, input logic u1, input logic [4:0] a2, input logic u2,
                       input logic iv, input logic iw, input logic [4:0] dst,
                       input logic w, input logic [4:0] wn, input logic [31:0] din);
        bus.r1 = a1;          bus.r1_used = u1;
        bus.r2 = a2;          bus.r2_used = u2;
        bus.issue_valid = iv; bus.issue_wr = iw; bus.issue_dst = dst;
        bus.we = w;           bus.wb_num = wn;   bus.wb_din = din;
    endtask

    task automatic step(input string n, input logic [3:0] m, input logic [31:0] d1,
                        input logic [31:0] d2, input logic st, input logic err);
        exp_t e;
        e.name = n; e.mask = m; e.d1 = d1; e.d2 = d2; e.st = st; e.err = err;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        rst_n = 1'b0;
        drv(5, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // reset state and release
        step("rst_hold", 4'b1111, 32'h0, 32'h0, 0, 0);
        rst_n = 1'b1;
        step("rst_rel", 4'b1111, 32'h0, 32'h0, 0, 0);

        // write-back bypass, then storage; zero register stays zero
        drv(7, 1, 0, 0, 0, 0, 0, 1, 7, 32'hDEADBEEF);
        step("byp7", 4'b1111, 32'hDEADBEEF, 32'h0, 0, 0);
        drv(7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("store7", 4'b1011, 32'hDEADBEEF, 32'h0, 0, 1);
        drv(0, 1, 7, 1, 0, 0, 0, 1, 0, 32'h1234);
        step("r0_wr", 4'b1111, 32'h0, 32'hDEADBEEF, 0, 1);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("r0_rd", 4'b1001, 32'h0, 32'h0, 0, 1);

        // asynchronous reset clears storage and sb_err
        rst_n = 1'b0;
        drv(5, 0, 7, 1, 0, 0, 0, 0, 0, 0);
        step("rst_mid1", 4'b0111, 32'h0, 32'h0, 0, 0);
        rst_n = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_rel2", 4'b0011, 32'h0, 32'h0, 0, 0);

        // RAW on r1 with one pending write
        drv(0, 0, 0, 0, 1, 1, 3, 0, 0, 0);
        step("iss3", 4'b0010, 32'h0, 32'h0, 0, 0);
        drv(3, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        step("raw_s1", 4'b0010, 32'h0, 32'h0, 1, 0);
        step("raw_s2", 4'b0010, 32'h0, 32'h0, 1, 0);
        step("raw_s3", 4'b0010, 32'h0, 32'h0, 1, 0);
        drv(3, 1, 0, 0, 1, 0, 0, 1, 3, 32'h55);
        step("raw_wb", 4'b1011, 32'h55, 32'h0, 0, 0);
        drv(3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("raw_after", 4'b1011, 32'h55, 32'h0, 0, 0);

        // same hazard but operand not used
        drv(0, 0, 0, 0, 1, 1, 3, 0, 0, 0);
        step("iss3b", 4'b0010, 32'h0, 32'h0, 0, 0);
        drv(3, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step("unused_1", 4'b0010, 32'h0, 32'h0, 0, 0);
        step("unused_2", 4'b0010, 32'h0, 32'h0, 0, 0);
        step("unused_3", 4'b0010, 32'h0, 32'h0, 0, 0);
        drv(3, 0, 0, 0, 1, 0, 0, 1, 3, 32'h66);
        step("unused_wb", 4'b1011, 32'h66, 32'h0, 0, 0);

        // RAW on r2
        drv(0, 0, 0, 0, 1, 1, 3, 0, 0, 0);
        step("iss3c", 4'b0010, 32'h0, 32'h0, 0, 0);
        drv(0, 0, 3, 1, 1, 0, 0, 0, 0, 0);
        step("raw2_s", 4'b0010, 32'h0, 32'h0, 1, 0);
        drv(0, 0, 3, 1, 1, 0, 0, 1, 3, 32'h77);
        step("raw2_wb", 4'b0111, 32'h0, 32'h77, 0, 0);

        // source equals destination: no self-stall, but the next reader waits
        drv(5, 1, 0, 0, 1, 1, 5, 0, 0, 0);
        step("self", 4'b0010, 32'h0, 32'h0, 0, 0);
        drv(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("self_pend", 4'b0010, 32'h0, 32'h0, 1, 0);
        drv(5, 1, 0, 0, 0, 0, 0, 1, 5, 32'h5A);
        step("self_wb", 4'b1011, 32'h5A, 32'h0, 0, 0);

        // saturation guard on register 9
        drv(0, 0, 0, 0, 1, 1, 9, 0, 0, 0);
        step("sat_i1", 4'b0010, 32'h0, 32'h0, 0, 0);
        step("sat_i2", 4'b0010, 32'h0, 32'h0, 0, 0);
        step("sat_i3", 4'b0010, 32'h0, 32'h0, 0, 0);
        step("sat_full", 4'b0010, 32'h0, 32'h0, 1, 0);
        drv(0, 0, 0, 0, 1, 1, 9, 1, 9, 32'hA0);
        step("sat_wb", 4'b0011, 32'h0, 32'h0, 1, 0);
        drv(0, 0, 0, 0, 1, 1, 9, 0, 0, 0);
        step("sat_go", 4'b0010, 32'h0, 32'h0, 0, 0);

        // draining three pending writes: only the last one releases the reader
        drv(9, 1, 0, 0, 0, 0, 0, 1, 9, 32'hA1);
        step("drain3", 4'b0011, 32'h0, 32'h0, 1, 0);
        drv(9, 1, 0, 0, 0, 0, 0, 1, 9, 32'hA2);
        step("drain2", 4'b0011, 32'h0, 32'h0, 1, 0);
        drv(9, 1, 0, 0, 0, 0, 0, 1, 9, 32'hA3);
        step("drain1", 4'b1011, 32'hA3, 32'h0, 0, 0);
        drv(9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("drained", 4'b1011, 32'hA3, 32'h0, 0, 0);

        // stray write-back sets sticky sb_err but still writes
        drv(4, 1, 0, 0, 0, 0, 0, 1, 4, 32'h44);
        step("err_wb", 4'b1011, 32'h44, 32'h0, 0, 0);
        drv(4, 1, 0, 0, 1, 1, 12, 0, 0, 0);
        step("err_set", 4'b1011, 32'h44, 32'h0, 0, 1);
        drv(12, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("err_hold", 4'b0011, 32'h0, 32'h0, 1, 1);

        // async reset mid-operation wipes counts; later write-back is stray
        rst_n = 1'b0;
        step("rst_async", 4'b1011, 32'h0, 32'h0, 0, 0);
        rst_n = 1'b1;
        drv(12, 1, 0, 0, 0, 0, 0, 1, 12, 32'h99);
        step("post_rst_wb", 4'b1011, 32'h99, 32'h0, 0, 0);
        drv(12, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("post_rst_err", 4'b1011, 32'h99, 32'h0, 0, 1);

        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: pending=%0d want=0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Register file with write-back bypass and a per-register pending-write scoreboard. It sits in the decode stage directly downstream of the read-register select logic. It consumes the selected read numbers `r1`/`r2` and returns operand data to the ID/EX latch. It also raises `stall` when an operand is still owed by an in-flight instruction, for example a multi-cycle `mul`.

## Interface
- `DATA_W`, default 32, register data width
- `ADDR_W`, default 5, register number width; the file holds 2^ADDR_W registers
- `CNT_W`, default 2, pending-write counter width per register; saturates at 2^CNT_W−1

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `r1`, `r2`  in  ADDR_W  read register numbers from the read-select stage
- `r1_used`, `r2_used`  in  1  the decoded instruction actually reads r1 / r2
- `r1_dout`, `r2_dout`  out  DATA_W  operand data
- `issue_valid`  in  1  the ID instruction is leaving ID this cycle, if not stalled
- `issue_wr`  in  1  the issuing instruction will write a register
- `issue_dst`  in  ADDR_W  destination register of the issuing instruction
- `we`  in  1  write-back enable
- `wb_num`  in  ADDR_W  write-back register number
- `wb_din`  in  DATA_W  write-back data
- `stall`  out  1  hold ID; the instruction must not issue
- `sb_err`  out  1  sticky flag: write-back to a register that has no pending write

## Operation
- Storage: 2^ADDR_W × DATA_W registers.
  - Register 0 always reads 0.
  - Writes to register 0 are dropped and never touch the scoreboard.
- Read: combinational.
  - If `we && wb_num==rN && rN!=0`, then `rN_dout = wb_din` (write-back bypass).
  - Otherwise `rN_dout` is the stored value.
- Scoreboard: one CNT_W-bit counter `pend[i]` per register.
  - Let `inc = issue_valid && !stall && issue_wr && issue_dst!=0`.
  - Let `dec = we && wb_num!=0 && pend[wb_num]!=0`.
  - Same register, both `inc` and `dec`: counter unchanged.
  - Otherwise the counter is incremented or decremented by one.
- A register is unresolved for operand N when `pend[rN]!=0` and not (`dec` on rN and `pend[rN]==1`). In the excepted case the bypass supplies the final value this cycle.
- `stall` = any of:
  - `r1_used` and r1 unresolved
  - `r2_used` and r2 unresolved
  - `issue_wr` and `pend[issue_dst]` at maximum (saturation guard)
- `stall` is combinational and independent of `issue_valid`.
- `sb_err` is set when `we && wb_num!=0 && pend[wb_num]==0`. The data write still happens. Only reset clears it.

## Timing
- Reset (async, `rst_n` low):
  - All registers = 0, all `pend` = 0, `sb_err` = 0.
  - Outputs settle combinationally: `r1_dout`/`r2_dout` = 0 (unless bypass), `stall` = 0.
- Write latency: the data is visible through the bypass in the same cycle as `we`, and from storage on every following cycle.
- Counter update: `pend` changes on the rising edge after the `inc`/`dec` cycle. `stall` reflects the new count from that edge onward.
- RAW with one pending write: the ID instruction stalls every cycle until the write-back cycle. It issues in the write-back cycle using the bypassed data.
- Two pending writes to the same register (count 2): the first write-back decrements to 1 and `stall` stays high. The instruction issues on the second write-back.
- An issuing instruction whose own source equals its destination: the stall check uses the pre-increment count. An instruction never stalls on itself.
- Reset mid-operation clears every pending count immediately. Any write-back after reset with a zero count sets `sb_err`. The pipeline is flushed by the same reset.

## Structure
- Shared CPU package (or header) holds `DATA_W`, `ADDR_W`, and the `REG_ZERO` constant used by decode and write-back.
- One natural sub-module: `sb_counter`, a single saturating up/down pending counter with `inc`, `dec`, and a `max` flag, instantiated 2^ADDR_W times.
- Storage, bypass mux and stall logic stay in the top level.

## Test plan
- Reset, then read r1=5, r2=0 → both `*_dout`=0, `stall`=0, `sb_err`=0.
- `we`=1, `wb_num`=7, `wb_din`=0xDEADBEEF, r1=7 in the same cycle → `r1_dout`=0xDEADBEEF that cycle and the next. A write to register 0 with `wb_din`=0x1234 → a later read of r0 returns 0.
- Issue with dst=3 (mul). Next instruction has r1=3, `r1_used`=1 → `stall`=1 for 3 cycles. Write-back to register 3 with 0x55 in cycle 4 → `stall`=0 in that cycle, `r1_dout`=0x55, `pend[3]` returns to 0.
- Same case as above, but with `r1_used`=0 and r1=3 → `stall`=0 throughout.
- Issue three writes to register 9 (count 3). A fourth instruction with dst=9 → `stall`=1. One write-back to register 9 → count 2, and the fourth instruction issues the next cycle.
- Write-back to register 4 with `pend[4]`=0 → `sb_err`=1, register 4 updated. `sb_err` stays set until `rst_n` goes low, which also zeroes all counters asynchronously.
